// File: rtl/alu_exec_stage.sv
// 8-bit CPU execute stage: latch op/operands, compute result and Z/C/N, drive one-cycle write-back.
// Latency: single-cycle ops write back one edge after accept; MUL (ALU_EXEC_MUL_EN) after DATA_WIDTH edges.
// Backpressure: in_ready drops only while a shift-add multiply runs; other ops sustain one per cycle.
module alu_exec_stage #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            op,
    input  logic [DATA_WIDTH-1:0] src_a,
    input  logic [DATA_WIDTH-1:0] src_b,
    input  logic [ADDR_WIDTH-1:0] dst_addr,
    output logic                  wb_we,
    output logic [ADDR_WIDTH-1:0] wb_addr,
    output logic [DATA_WIDTH-1:0] wb_data,
    output logic                  flag_z,
    output logic                  flag_c,
    output logic                  flag_n,
    output logic                  busy
);
    localparam int W  = DATA_WIDTH;
    localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR  = 4'd3,
                           OP_XOR = 4'd4, OP_NOT = 4'd5, OP_SHL = 4'd6, OP_SHR = 4'd7,
                           OP_MUL = 4'd8, OP_CMP = 4'd9, OP_MOV = 4'd10;

    logic                  s1_vld_q, s1_vld_d;
    logic [3:0]            op_q, op_d;
    logic [W-1:0]          a_q, a_d, b_q, b_d;
    logic [ADDR_WIDTH-1:0] dst_q, dst_d;
    logic                  wb_we_q, wb_we_d;
    logic [ADDR_WIDTH-1:0] wb_addr_q, wb_addr_d;
    logic [W-1:0]          wb_data_q, wb_data_d;
    logic                  z_q, z_d, c_q, c_d, n_q, n_d;
    logic                  accept;

    logic [W-1:0] alu_res;
    logic         alu_c, alu_we, alu_fl;

`ifdef ALU_EXEC_MUL_EN
    localparam int CW = (W > 1) ? $clog2(W) : 1;
    typedef enum logic {ST_IDLE, ST_MUL} state_t;
    state_t        state_q, state_d;
    logic [2*W-1:0] acc_q, acc_d, acc_nxt;
    logic [CW-1:0] cnt_q, cnt_d;

    assign in_ready = (state_q == ST_IDLE);
    assign busy     = (state_q == ST_MUL);
    // One multiplier bit per cycle, LSB first, partial product aligned by the bit index.
    assign acc_nxt  = acc_q + (b_q[cnt_q] ? ({{W{1'b0}}, a_q} << cnt_q) : '0);
`else
    assign in_ready = 1'b1;
    assign busy     = 1'b0;
`endif

    assign accept = in_valid && in_ready;

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_we  = 1'b1;
        alu_fl  = 1'b1;
        case (op_q)
            OP_ADD: {alu_c, alu_res} = {1'b0, a_q} + {1'b0, b_q};
            OP_SUB, OP_CMP: begin
                alu_res = a_q - b_q;
                alu_c   = (a_q < b_q);
                alu_we  = (op_q == OP_SUB);
            end
            OP_AND: alu_res = a_q & b_q;
            OP_OR:  alu_res = a_q | b_q;
            OP_XOR: alu_res = a_q ^ b_q;
            OP_NOT: alu_res = ~a_q;
            OP_SHL: begin
                alu_res = {a_q[W-2:0], 1'b0};
                alu_c   = a_q[W-1];
            end
            OP_SHR: begin
                alu_res = {1'b0, a_q[W-1:1]};
                alu_c   = a_q[0];
            end
            OP_MOV: alu_res = b_q;
            default: begin
                alu_we = 1'b0;
                alu_fl = 1'b0;
            end
        endcase
    end

    always_comb begin
        s1_vld_d  = 1'b0;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        dst_d     = dst_q;
        wb_we_d   = 1'b0;
        wb_addr_d = wb_addr_q;
        wb_data_d = wb_data_q;
        z_d       = z_q;
        c_d       = c_q;
        n_d       = n_q;
`ifdef ALU_EXEC_MUL_EN
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
`endif
        if (accept) begin
            op_d     = op;
            a_d      = src_a;
            b_d      = src_b;
            dst_d    = dst_addr;
            s1_vld_d = 1'b1;
`ifdef ALU_EXEC_MUL_EN
            if (op == OP_MUL) begin
                s1_vld_d = 1'b0;
                state_d  = ST_MUL;
                acc_d    = '0;
                cnt_d    = '0;
            end
`endif
        end
        if (s1_vld_q) begin
            if (alu_we) begin
                wb_we_d   = 1'b1;
                wb_addr_d = dst_q;
                wb_data_d = alu_res;
            end
            if (alu_fl) begin
                z_d = (alu_res == '0);
                c_d = alu_c;
                n_d = alu_res[W-1];
            end
        end
`ifdef ALU_EXEC_MUL_EN
        if (state_q == ST_MUL) begin
            acc_d = acc_nxt;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(W - 1)) begin
                state_d   = ST_IDLE;
                wb_we_d   = 1'b1;
                wb_addr_d = dst_q;
                wb_data_d = acc_nxt[W-1:0];
                z_d       = (acc_nxt[W-1:0] == '0);
                c_d       = |acc_nxt[2*W-1:W];
                n_d       = acc_nxt[W-1];
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q  <= 1'b0;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            dst_q     <= '0;
            wb_we_q   <= 1'b0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
            z_q       <= 1'b0;
            c_q       <= 1'b0;
            n_q       <= 1'b0;
        end else begin
            s1_vld_q  <= s1_vld_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            dst_q     <= dst_d;
            wb_we_q   <= wb_we_d;
            wb_addr_q <= wb_addr_d;
            wb_data_q <= wb_data_d;
            z_q       <= z_d;
            c_q       <= c_d;
            n_q       <= n_d;
        end
    end

`ifdef ALU_EXEC_MUL_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end
`endif

    assign wb_we   = wb_we_q;
    assign wb_addr = wb_addr_q;
    assign wb_data = wb_data_q;
    assign flag_z  = z_q;
    assign flag_c  = c_q;
    assign flag_n  = n_q;
endmodule

// File: tb/tb_alu_exec_stage.sv
// Bench for alu_exec_stage: integer-arithmetic model with a due-cycle queue, per-cycle compare, literal pins.
module tb_alu_exec_stage;
    localparam int W  = 8;
    localparam int AW = 3;
    localparam int M  = 1 << W;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [3:0]    op = '0;
    logic [W-1:0]  src_a = '0, src_b = '0;
    logic [AW-1:0] dst_addr = '0;
    logic          wb_we, flag_z, flag_c, flag_n, busy;
    logic [AW-1:0] wb_addr;
    logic [W-1:0]  wb_data;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    alu_exec_stage #(.DATA_WIDTH(W), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .src_a(src_a), .src_b(src_b), .dst_addr(dst_addr),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .flag_z(flag_z), .flag_c(flag_c), .flag_n(flag_n), .busy(busy)
    );

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // ---------------- model ----------------
    typedef struct {
        int due; bit we; bit fl; bit is_mul;
        int addr; int data; bit z; bit c; bit n;
    } item_t;

    item_t q[$];
    int    cyc = 0;
    bit    m_ready = 1'b1, m_busy = 1'b0;
    bit    e_we = 1'b0, e_z = 1'b0, e_c = 1'b0, e_n = 1'b0;
    int    e_addr = 0, e_data = 0;
    bit    m_acc;
    item_t m_it;

    function automatic item_t model_op(input int o, input int a, input int b, input int d);
        item_t it;
        int r, p;
        it = '{default: 0};
        it.addr = d;
        it.we = 1'b1;
        it.fl = 1'b1;
        r = 0;
        case (o)
            0:  begin r = a + b; it.c = (r >= M); end
            1:  begin r = a - b + M; it.c = (a < b); end
            2:  r = a & b;
            3:  r = a | b;
            4:  r = a ^ b;
            5:  r = M - 1 - a;
            6:  begin r = a * 2; it.c = (a >= M / 2); end
            7:  begin r = a / 2; it.c = (a % 2 == 1); end
`ifdef ALU_EXEC_MUL_EN
            8:  begin p = a * b; r = p; it.c = (p >= M); it.is_mul = 1'b1; end
`endif
            9:  begin r = a - b + M; it.c = (a < b); it.we = 1'b0; end
            10: r = b;
            default: begin it.we = 1'b0; it.fl = 1'b0; end
        endcase
        it.data = r % M;
        it.z = (it.data == 0);
        it.n = (it.data >= M / 2);
        return it;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            cyc = 0;
            m_ready = 1'b1; m_busy = 1'b0;
            e_we = 1'b0; e_addr = 0; e_data = 0;
            e_z = 1'b0; e_c = 1'b0; e_n = 1'b0;
        end else begin
            m_acc = in_valid && m_ready;
            cyc++;
            e_we = 1'b0;
            if (q.size() > 0 && q[0].due == cyc) begin
                m_it = q.pop_front();
                if (m_it.we) begin
                    e_we = 1'b1; e_addr = m_it.addr; e_data = m_it.data;
                end
                if (m_it.fl) begin
                    e_z = m_it.z; e_c = m_it.c; e_n = m_it.n;
                end
            end
            if (m_acc) begin
                m_it = model_op(int'(op), int'(src_a), int'(src_b), int'(dst_addr));
                m_it.due = cyc + (m_it.is_mul ? W : 1);
                if (m_it.we || m_it.fl || m_it.is_mul) q.push_back(m_it);
            end
            m_busy = 1'b0;
            foreach (q[i]) if (q[i].is_mul) m_busy = 1'b1;
            m_ready = !m_busy;
        end
    end

    always @(negedge clk) begin
        chk("in_ready", in_ready, m_ready);
        chk("busy", busy, m_busy);
        chk("wb_we", wb_we, e_we);
        chk("wb_addr", wb_addr, e_addr);
        chk("wb_data", wb_data, e_data);
        chk("flag_z", flag_z, e_z);
        chk("flag_c", flag_c, e_c);
        chk("flag_n", flag_n, e_n);
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic issue(input int o, input int a, input int b, input int d, output int tries);
        bit acc_now;
        op = o[3:0]; src_a = a[W-1:0]; src_b = b[W-1:0]; dst_addr = d[AW-1:0];
        in_valid = 1'b1;
        tries = 0;
        acc_now = 1'b0;
        while (!acc_now && tries < 40) begin
            acc_now = in_ready;
            tries++;
            step();
        end
        chk("accept_in_bound", acc_now, 1);
    endtask

    task automatic lit(input string nm, input int we, input int addr, input int data,
                       input int z, input int c, input int n);
        chk({nm, ".we"}, wb_we, we);
        chk({nm, ".addr"}, wb_addr, addr);
        chk({nm, ".data"}, wb_data, data);
        chk({nm, ".z"}, flag_z, z);
        chk({nm, ".c"}, flag_c, c);
        chk({nm, ".n"}, flag_n, n);
    endtask

    initial begin
        int t, t2;
        rst_n = 1'b0;
        in_valid = 1'b1; op = 4'd0; src_a = 8'h12; src_b = 8'h34; dst_addr = 3'd5;
        repeat (3) step();
        lit("reset", 0, 0, 0, 0, 0, 0);
        chk("reset.in_ready", in_ready, 1);
        chk("reset.busy", busy, 0);
        in_valid = 1'b0;
        rst_n = 1'b1;
        step();

        issue(0, 8'h55, 8'hAA, 1, t); in_valid = 1'b0; step();
        lit("add", 1, 1, 8'hFF, 0, 0, 1);
        issue(0, 8'hFF, 8'h01, 2, t); in_valid = 1'b0; step();
        lit("add_carry", 1, 2, 8'h00, 1, 1, 0);
        issue(1, 8'h10, 8'h20, 3, t); in_valid = 1'b0; step();
        lit("sub_borrow", 1, 3, 8'hF0, 0, 1, 1);
        issue(9, 8'h33, 8'h33, 4, t); in_valid = 1'b0; step();
        lit("cmp", 0, 3, 8'hF0, 1, 0, 0);

        issue(2, 8'hF0, 8'h0F, 1, t); chk("b2b_and_tries", t, 1);
        issue(3, 8'hF0, 8'h0F, 2, t); chk("b2b_or_tries", t, 1);
        lit("b2b_and", 1, 1, 8'h00, 1, 0, 0);
        issue(4, 8'hF0, 8'h0F, 3, t); chk("b2b_xor_tries", t, 1);
        lit("b2b_or", 1, 2, 8'hFF, 0, 0, 1);
        issue(6, 8'h81, 8'h00, 4, t); chk("b2b_shl_tries", t, 1);
        lit("b2b_xor", 1, 3, 8'hFF, 0, 0, 1);
        issue(7, 8'h81, 8'h00, 5, t); chk("b2b_shr_tries", t, 1);
        in_valid = 1'b0;
        lit("shl", 1, 4, 8'h02, 0, 1, 0);
        step();
        lit("shr", 1, 5, 8'h40, 0, 1, 0);
        step();

`ifndef ALU_EXEC_MUL_EN
        issue(8, 8'h0C, 8'h0B, 6, t); in_valid = 1'b0;
        chk("mul_off.tries", t, 1);
        step();
        lit("mul_off", 0, 5, 8'h40, 0, 1, 0);
        chk("mul_off.in_ready", in_ready, 1);
        chk("mul_off.busy", busy, 0);
        step();
        chk("mul_off.we_later", wb_we, 0);
`else
        issue(8, 8'h0C, 8'h0B, 6, t); in_valid = 1'b0;
        chk("mul.busy_start", busy, 1);
        chk("mul.ready_start", in_ready, 0);
        repeat (7) step();
        chk("mul.we_early", wb_we, 0);
        chk("mul.busy_mid", busy, 1);
        step();
        lit("mul", 1, 6, 8'h84, 0, 0, 1);
        chk("mul.ready_end", in_ready, 1);
        chk("mul.busy_end", busy, 0);

        issue(8, 8'h10, 8'h10, 7, t); in_valid = 1'b0;
        repeat (8) step();
        lit("mul_zero", 1, 7, 8'h00, 1, 1, 0);

        issue(8, 8'h03, 8'h05, 2, t);
        issue(0, 8'h01, 8'h02, 1, t2); in_valid = 1'b0;
        chk("mul_stall_tries", t2, 9);
        step();
        lit("add_after_mul", 1, 1, 8'h03, 0, 0, 0);

        issue(8, 8'hFF, 8'hFF, 2, t); in_valid = 1'b0;
        repeat (3) step();
        rst_n = 1'b0;
        #1;
        chk("rst_mid.busy", busy, 0);
        chk("rst_mid.ready", in_ready, 1);
        lit("rst_mid", 0, 0, 0, 0, 0, 0);
        step(); step();
        rst_n = 1'b1;
        repeat (10) step();
        chk("rst_mid.no_wb", wb_we, 0);
`endif

        issue(0, 8'h20, 8'h22, 6, t); in_valid = 1'b0; step();
        lit("add_final", 1, 6, 8'h42, 0, 0, 0);
        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/alu_exec_stage.md
# alu_exec_stage

Execute stage of the 8-bit CPU, directly downstream of the register file. Accepts an opcode, two operands (the register file's two read ports) and a destination address through a valid/ready handshake. Computes the result, registers Z/C/N flags, and drives a one-cycle write-back strobe (`wb_we`, `wb_addr`, `wb_data`) that connects straight to the register file's `we`, `wr_addr` and `wr_data` ports. Most ops are single-cycle; MUL is an iterative shift-add that stalls the handshake.

## Interface
- `DATA_WIDTH`, 8, operand/result width.
- `ADDR_WIDTH`, 3, destination register address width.
- `clk`  in  1  clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  upstream has an operation.
- `in_ready`  out  1  block can accept an operation.
- `op`  in  4  opcode.
- `src_a`  in  DATA_WIDTH  operand A (from `rd_data1`).
- `src_b`  in  DATA_WIDTH  operand B (from `rd_data2`).
- `dst_addr`  in  ADDR_WIDTH  destination register.
- `wb_we`  out  1  write-back strobe, one cycle per writing op.
- `wb_addr`  out  ADDR_WIDTH  write-back address.
- `wb_data`  out  DATA_WIDTH  write-back data.
- `flag_z`, `flag_c`, `flag_n`  out  1 each  registered flags.
- `busy`  out  1  multiply in progress.

## Operation
- Accept occurs on a rising edge with `in_valid && in_ready`. At accept, `op`, `src_a`, `src_b` and `dst_addr` are latched, so later register-file changes do not affect the operation.
- Opcodes:
  - 0 ADD: a+b; C = carry-out bit DATA_WIDTH.
  - 1 SUB: a−b; C = borrow (a<b).
  - 2 AND, 3 OR, 4 XOR: C=0.
  - 5 NOT: ~a; C=0.
  - 6 SHL: a<<1; C=a[MSB].
  - 7 SHR: logical a>>1; C=a[0].
  - 8 MUL: low DATA_WIDTH bits of a*b; C = (high half ≠ 0).
  - 9 CMP: flags as SUB, no write (`wb_we`=0).
  - 10 MOV: result = b; C=0.
  - 11–15 NOP: no write, flags unchanged.
- Flags for all writing ops and CMP: Z = (result==0) and N = result[MSB]. Arithmetic is modulo 2^DATA_WIDTH.
- FSM has two states:
  - IDLE: `in_ready`=1. A single-cycle op is accepted and its result is registered. A MUL accept moves to MUL.
  - MUL: `in_ready`=0, `busy`=1. Shift-add runs for DATA_WIDTH cycles using a 2·DATA_WIDTH-bit accumulator, one bit of b per cycle, LSB first. On the final iteration the block returns to IDLE and asserts the write-back.
- `in_valid` while `in_ready`=0 is ignored. Upstream holds its request.
- Reset values: all outputs 0 except `in_ready`=1. State is IDLE. Accumulator is 0.
- Reset asserted mid-MUL aborts the operation. No write-back is issued and no flags are updated.

## Timing
- Single-cycle op accepted at edge N: `wb_*` and flags valid after edge N+1. `wb_we` is high for exactly one cycle.
- Back-to-back single-cycle ops sustain full throughput of one per cycle.
- MUL accepted at edge N: `busy`/`in_ready` change after edge N. `wb_we` is high after edge N+DATA_WIDTH (8 cycles at default), for one cycle. `in_ready` returns to 1 in that same cycle.
- `wb_addr` and `wb_data` hold their last values when `wb_we`=0.
- No combinational path exists from inputs to outputs. `in_ready` depends on state only.

## Configuration
- Macro: `ALU_EXEC_MUL_EN`.
- Defined: MUL implemented as described, with the MUL state, accumulator and `busy`.
- Undefined: opcode 8 behaves as NOP (no write, flags unchanged, single cycle). `busy` is tied to 0 and `in_ready` is tied to 1.

## Test plan
- Reset: hold `rst_n`=0 with stimulus active. Required: `wb_we`=0, flags=0, `in_ready`=1. After release, ADD a=0x55 b=0xAA dst=1 gives `wb_we`=1, `wb_addr`=1, `wb_data`=0xFF, Z=0, C=0, N=1.
- Carry/zero: ADD 0xFF+0x01 gives 0x00, Z=1, C=1. SUB 0x10−0x20 gives 0xF0, C=1, N=1. CMP 0x33,0x33 gives Z=1 and `wb_we` stays 0.
- Back-to-back: AND, OR, XOR, SHL(0x81), SHR(0x81) on consecutive cycles. Required: five consecutive `wb_we` pulses with data 0x00-class correct values. SHL yields 0x02 with C=1; SHR yields 0x40 with C=1.
- MUL (macro on): 0x0C×0x0B gives `wb_data`=0x84, C=0, 8 cycles after accept. 0x10×0x10 gives 0x00, Z=1, C=1. A new `in_valid` during `busy` is not accepted until `in_ready` returns.
- Reset mid-MUL: deassert `rst_n` 4 cycles into 0xFF×0xFF. Required: no `wb_we`, `busy`=0 immediately, and an ADD afterward completes normally.
- Macro off: MUL 0x0C×0x0B gives no `wb_we`, flags unchanged, and `in_ready` stays 1.
